// File: rtl/result_display_if.sv
// Bundle between the CPU-side value source and the 7-segment display driver.
// The display driver is the slave: it reads the value/control inputs and drives the board pins.
interface result_display_if;
  logic [15:0] in_result;
  logic [31:0] in_pc;
  logic        sel_pc;
  logic        freeze;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output in_result, in_pc, sel_pc, freeze, input an, seg, dp);
  modport slave  (input in_result, in_pc, sel_pc, freeze, output an, seg, dp);
endinterface

// File: rtl/result_display_driver.sv
// Shows a sampled 16-bit CPU value as four hex digits on a time-multiplexed 7-segment display.
// The value is resampled only at frame wrap, so each frame always shows one coherent value.
module result_display_driver #(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  result_display_if.slave  bus
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DIG_W  = 2;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned AN_W   = 4;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIG_W-1:0] digit_q, digit_d;
  logic [VAL_W-1:0] disp_val_q, disp_val_d;
  logic             disp_mode_q, disp_mode_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick_c;
  logic [3:0]       nib_c;
  logic             lz_c;
  logic             unused_pc_hi;

  assign unused_pc_hi = &{1'b0, bus.in_pc[31:16]};

  // Active-low gfedcba hex decode.
  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tick_c      = 1'b0;
    div_d       = div_q;
    digit_d     = digit_q;
    disp_val_d  = disp_val_q;
    disp_mode_d = disp_mode_q;
    nib_c       = 4'h0;
    lz_c        = 1'b0;

    tick_c = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick_c ? '0 : div_q + DIV_W'(1);

    if (tick_c) begin
      digit_d = digit_q + DIG_W'(1);
      // Frame wrap: the only point where a new value may enter the display.
      if (digit_q == DIG_W'(3) && !bus.freeze) begin
        disp_val_d  = bus.sel_pc ? bus.in_pc[15:0] : bus.in_result;
        disp_mode_d = bus.sel_pc;
      end
    end

    case (digit_q)
      2'd0: begin nib_c = disp_val_q[3:0];   lz_c = 1'b0;                       end
      2'd1: begin nib_c = disp_val_q[7:4];   lz_c = (disp_val_q[15:4]  == '0); end
      2'd2: begin nib_c = disp_val_q[11:8];  lz_c = (disp_val_q[15:8]  == '0); end
      default: begin nib_c = disp_val_q[15:12]; lz_c = (disp_val_q[15:12] == '0); end
    endcase

    an_d  = ~(AN_W'(1) << digit_q);
    seg_d = (BLANK_LZ && lz_c) ? '1 : hex7(nib_c);
    dp_d  = ~(disp_mode_q && (digit_q == DIG_W'(0)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      digit_q     <= '0;
      disp_val_q  <= '0;
      disp_mode_q <= 1'b0;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
    end else begin
      div_q       <= div_d;
      digit_q     <= digit_d;
      disp_val_q  <= disp_val_d;
      disp_mode_q <= disp_mode_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver with a 4-cycle digit slot.
module tb_result_display_driver;

  localparam logic [6:0] BLK = 7'b1111111;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  result_display_if bus ();

  result_display_driver #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the current slot's pins, then advance to the start of the next slot.
  task automatic check_slot(input string tag, input logic [3:0] an, input logic [6:0] seg,
                            input logic dp);
    check({tag, ".an"},  16'(bus.an),  16'(an));
    check({tag, ".seg"}, 16'(bus.seg), 16'(seg));
    check({tag, ".dp"},  16'(bus.dp),  16'(dp));
    repeat (4) step();
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    bus.in_result = 16'h12AF;
    bus.in_pc     = 32'h0;
    bus.sel_pc    = 1'b0;
    bus.freeze    = 1'b0;

    #12;
    check("rst.an",  16'(bus.an),  16'hF);
    check("rst.seg", 16'(bus.seg), 16'(BLK));
    check("rst.dp",  16'(bus.dp),  16'h1);

    @(negedge clk);
    rst = 1'b1;
    step();
    check("rel.an",  16'(bus.an),  16'hE);
    check("rel.seg", 16'(bus.seg), 16'(7'b1000000));
    check("rel.dp",  16'(bus.dp),  16'h1);
    repeat (3) step();
    check("tick.hold.an", 16'(bus.an), 16'hE);
    step();
    check_slot("f0.d1", 4'b1101, BLK, 1'b1);
    check_slot("f0.d2", 4'b1011, BLK, 1'b1);
    check_slot("f0.d3", 4'b0111, BLK, 1'b1);

    // Frame 1: 12AF; input changes while digit 1 is showing.
    check_slot("f1.d0", 4'b1110, 7'b0001110, 1'b1);
    bus.in_result = 16'h0005;
    check_slot("f1.d1", 4'b1101, 7'b0001000, 1'b1);
    check_slot("f1.d2", 4'b1011, 7'b0100100, 1'b1);
    check_slot("f1.d3", 4'b0111, 7'b1111001, 1'b1);

    // Frame 2: 0005 with leading zeros blanked.
    check_slot("f2.d0", 4'b1110, 7'b0010010, 1'b1);
    bus.sel_pc = 1'b1;
    bus.in_pc  = 32'h0000_0040;
    check_slot("f2.d1", 4'b1101, BLK, 1'b1);
    check_slot("f2.d2", 4'b1011, BLK, 1'b1);
    check_slot("f2.d3", 4'b0111, BLK, 1'b1);

    // Frame 3: PC 0040 with marker on digit 0.
    check_slot("f3.d0", 4'b1110, 7'b1000000, 1'b0);
    check_slot("f3.d1", 4'b1101, 7'b0011001, 1'b1);
    bus.sel_pc    = 1'b0;
    bus.in_result = 16'h1234;
    check_slot("f3.d2", 4'b1011, BLK, 1'b1);
    check_slot("f3.d3", 4'b0111, BLK, 1'b1);

    // Frame 4: 1234; freeze across the next wrap while the input moves to ABCD.
    check_slot("f4.d0", 4'b1110, 7'b0011001, 1'b1);
    bus.in_result = 16'hABCD;
    bus.freeze    = 1'b1;
    check_slot("f4.d1", 4'b1101, 7'b0110000, 1'b1);
    check_slot("f4.d2", 4'b1011, 7'b0100100, 1'b1);
    check_slot("f4.d3", 4'b0111, 7'b1111001, 1'b1);

    check_slot("f5.d0", 4'b1110, 7'b0011001, 1'b1);
    bus.freeze = 1'b0;
    check_slot("f5.d1", 4'b1101, 7'b0110000, 1'b1);
    check_slot("f5.d2", 4'b1011, 7'b0100100, 1'b1);
    check_slot("f5.d3", 4'b0111, 7'b1111001, 1'b1);

    check_slot("f6.d0", 4'b1110, 7'b0100001, 1'b1);
    check_slot("f6.d1", 4'b1101, 7'b1000110, 1'b1);
    check_slot("f6.d2", 4'b1011, 7'b0000011, 1'b1);
    check_slot("f6.d3", 4'b0111, 7'b0001000, 1'b1);

    // Asynchronous reset in the middle of digit 1's slot.
    repeat (5) step();
    #3;
    rst = 1'b0;
    #1;
    check("mid.rst.an",  16'(bus.an),  16'hF);
    check("mid.rst.seg", 16'(bus.seg), 16'(BLK));
    check("mid.rst.dp",  16'(bus.dp),  16'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("mid.rel.an",  16'(bus.an),  16'hE);
    check("mid.rel.seg", 16'(bus.seg), 16'(7'b1000000));
    repeat (4) step();
    check_slot("mid.rel.d1", 4'b1101, BLK, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
